// File: rtl/vec_ram_wr_arbiter_pkg.sv
// Shared vector-register types: lane/vector typedefs, lane count, client ids
// and the write-sequencer state encoding.
package vec_ram_wr_arbiter_pkg;

    localparam int VEC_LANES  = 16;
    localparam int VEC_LANE_W = 8;

    typedef logic [VEC_LANE_W-1:0] vec_lane_t;
    typedef vec_lane_t [VEC_LANES-1:0] vec_t;

    typedef enum logic {
        CLIENT_ALU = 1'b0,
        CLIENT_LSU = 1'b1
    } client_id_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } wr_state_e;

endpackage

// File: rtl/vec_ram_wr_arbiter_if.sv
// Request bundle of the two vector write clients (ALU writeback, load unit).
interface vec_ram_wr_arbiter_if
    import vec_ram_wr_arbiter_pkg::*;
#(
    parameter int VEC_SIZE        = VEC_LANE_W,
    parameter int VEC_INDEX_WIDTH = 4
) ();

    logic [1:0]                                i_req_valid;
    logic [1:0]                                o_req_ready;
    logic [1:0][VEC_INDEX_WIDTH-1:0]           i_req_addr;
    logic [1:0][VEC_LANES-1:0][VEC_SIZE-1:0]   i_req_data;
    logic [1:0][VEC_LANES-1:0]                 i_req_mask;

    modport master (
        output i_req_valid, i_req_addr, i_req_data, i_req_mask,
        input  o_req_ready
    );

    modport slave (
        input  i_req_valid, i_req_addr, i_req_data, i_req_mask,
        output o_req_ready
    );

endinterface

// File: rtl/vec_ram_wr_arbiter_rr_arb2.sv
// Two-way round-robin grant; the last-grant pointer moves only when a grant
// is issued, and a grant always means the request is accepted.
module vec_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_valid,
    input  logic       i_enable,
    output logic [1:0] o_grant
);

    logic       last_q;
    logic       last_d;
    logic [1:0] grant;

    always_comb begin
        grant = i_valid;
        if (i_valid == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
        if (!i_enable) begin
            grant = 2'b00;
        end
    end

    always_comb begin
        last_d = last_q;
        if (grant[1]) begin
            last_d = 1'b1;
        end else if (grant[0]) begin
            last_d = 1'b0;
        end
    end

    // Pointer starts at client 1 so client 0 wins the first conflict.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign o_grant = grant;

endmodule

// File: rtl/vec_ram_wr_arbiter.sv
// Vector RAM write-port arbiter: round-robin between two clients, full-mask
// writes go straight out, partial masks do a read-modify-write over port B.
module vec_ram_wr_arbiter
    import vec_ram_wr_arbiter_pkg::*;
#(
    parameter int VEC_SIZE        = VEC_LANE_W,
    parameter int VEC_INDEX_WIDTH = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    vec_ram_wr_arbiter_if.slave                req_if,
    output logic                               o_ram_write_enable,
    output logic [VEC_INDEX_WIDTH-1:0]         o_ram_write_addr,
    output logic [VEC_LANES-1:0][VEC_SIZE-1:0] o_ram_write_data,
    output logic [VEC_INDEX_WIDTH-1:0]         o_ram_read_addr_b,
    input  logic [VEC_LANES-1:0][VEC_SIZE-1:0] i_ram_read_data_b,
    output logic                               o_busy,
    output logic [1:0]                         o_done
);

    wr_state_e                          state_q, state_d;
    client_id_e                         id_q, id_d;
    logic [VEC_INDEX_WIDTH-1:0]         addr_q, addr_d;
    logic [VEC_LANES-1:0][VEC_SIZE-1:0] data_q, data_d;
    logic [VEC_LANES-1:0]               mask_q, mask_d;
    logic                               we_q, we_d;
    logic [VEC_INDEX_WIDTH-1:0]         waddr_q, waddr_d;
    logic [VEC_LANES-1:0][VEC_SIZE-1:0] wdata_q, wdata_d;
    logic [VEC_INDEX_WIDTH-1:0]         raddr_q, raddr_d;
    logic [1:0]                         done_q, done_d;

    logic [1:0]                         grant;
    logic                               accept;
    client_id_e                         acc_id;
    logic [VEC_INDEX_WIDTH-1:0]         acc_addr;
    logic [VEC_LANES-1:0][VEC_SIZE-1:0] acc_data;
    logic [VEC_LANES-1:0]               acc_mask;
    logic [VEC_LANES-1:0][VEC_SIZE-1:0] merged;

    // Ready is forced low under reset and while the RMW read is in flight.
    vec_rr_arb2 u_arb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (req_if.i_req_valid),
        .i_enable (i_rst_n && (state_q != READ)),
        .o_grant  (grant)
    );

    assign req_if.o_req_ready = grant;
    assign accept   = |grant;
    assign acc_id   = client_id_e'(grant[1]);
    assign acc_addr = req_if.i_req_addr[grant[1]];
    assign acc_data = req_if.i_req_data[grant[1]];
    assign acc_mask = req_if.i_req_mask[grant[1]];

    for (genvar gi = 0; gi < VEC_LANES; gi++) begin : g_merge
        assign merged[gi] = mask_q[gi] ? data_q[gi] : i_ram_read_data_b[gi];
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        raddr_d = raddr_q;
        done_d  = 2'b00;
        if (state_q == READ) begin
            state_d      = WRITE;
            we_d         = 1'b1;
            waddr_d      = addr_q;
            wdata_d      = merged;
            done_d[id_q] = 1'b1;
        end else begin
            state_d = IDLE;
            if (accept) begin
                id_d   = acc_id;
                addr_d = acc_addr;
                data_d = acc_data;
                mask_d = acc_mask;
                if (acc_mask == '1) begin
                    state_d        = WRITE;
                    we_d           = 1'b1;
                    waddr_d        = acc_addr;
                    wdata_d        = acc_data;
                    done_d[acc_id] = 1'b1;
                end else if (acc_mask == '0) begin
                    done_d[acc_id] = 1'b1;
                end else begin
                    // Port B address is launched with the READ cycle itself.
                    state_d = READ;
                    raddr_d = acc_addr;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            id_q    <= CLIENT_ALU;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            raddr_q <= '0;
            done_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            raddr_q <= raddr_d;
            done_q  <= done_d;
        end
    end

    assign o_ram_write_enable = we_q;
    assign o_ram_write_addr   = waddr_q;
    assign o_ram_write_data   = wdata_q;
    assign o_ram_read_addr_b  = raddr_q;
    assign o_done             = done_q;
    assign o_busy             = (state_q != IDLE) || accept;

endmodule
